rmt_ingress_filter: RTL and testbench

//  Sits directly upstream of rmt_wrapper. It classifies each 512-bit AXIS packet from its first beat.
//  - Control packets (UDP to CTRL_UDP_PORT) are steered to the control output.
//  - All other packets go to the data output, which feeds the RMT parser.
//  - Control packets arriving while ctrl_en=0 are dropped, so tables cannot be rewritten at runtime.

---
 rtl/rmt_pkt_pkg.sv | 21 ++
 rtl/axis_reg_slice.sv | 80 ++++++++
 rtl/rmt_ingress_filter.sv | 160 ++++++++++++++++
 tb/tb_rmt_ingress_filter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_pkt_pkg.sv
// Shared definitions for the RMT ingress filter.
// Holds header byte offsets inside beat 0, the protocol constants used to
// recognise a control packet, and the filter FSM state type.
package rmt_pkt_pkg;

  // Byte offsets within beat 0 (byte n = tdata[8n+7:8n])
  localparam int ETH_TYPE_OFF  = 12;
  localparam int IP_PROTO_OFF  = 23;
  localparam int UDP_DPORT_OFF = 36;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPPROTO_UDP    = 8'h11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD_DATA = 2'd1,
    FWD_CTRL = 2'd2,
    DROP     = 2'd3
  } filt_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered AXIS stage carrying tdata/tkeep/tuser/tlast.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready/in_*         upstream side
//   out_valid/out_ready/out_*      downstream side (all outputs registered)
// Handshake: a beat moves across an interface on a rising clock edge where
// valid and ready are both 1; valid never depends on ready, and a presented
// beat stays stable until it is taken.
// The stage accepts whenever it is empty or being drained in the same cycle,
// so a continuous stream passes at one beat per clock with one cycle of latency.
module axis_reg_slice #(
  parameter int DW = 512,
  parameter int KW = 64,
  parameter int UW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [KW-1:0] in_keep,
  input  logic [UW-1:0] in_user,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [KW-1:0] out_keep,
  output logic [UW-1:0] out_user,
  output logic          out_last
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [KW-1:0] keep_q, keep_d;
  logic [UW-1:0] user_q, user_d;
  logic          last_q, last_d;
  logic          load;

  always_comb begin
    in_ready = ~valid_q | out_ready;
    load     = in_valid & in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    keep_d   = keep_q;
    user_d   = user_q;
    last_d   = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      keep_d  = in_keep;
      user_d  = in_user;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      user_q  <= user_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_user  = user_q;
  assign out_last  = last_q;

endmodule

// File: rtl/rmt_ingress_filter.sv
// Ingress filter in front of rmt_wrapper. Each packet is classified from its
// first beat: UDP/IPv4 packets to CTRL_UDP_PORT go to the control output
// (c_axis) when ctrl_en=1 and are discarded when ctrl_en=0; everything else
// goes to the data output (m_axis). Each output has a one-entry register slice.
// Ports:
//   clk, areset          clock, asynchronous active-high reset
//   s_axis_*             ingress stream
//   m_axis_*             data path to rmt_wrapper
//   c_axis_*             control path to the config loader
//   ctrl_en              1 = forward control packets, 0 = drop them
//   dbg_state            current FSM state (filt_state_t encoding)
//   stat_*_pkts          saturating packet counters, only with RMT_FILTER_STATS_EN
// Handshake: a beat moves on a rising clock edge where tvalid and tready are
// both 1; tvalid never waits on tready, and a presented beat holds until taken.
// Optional feature macro: RMT_FILTER_STATS_EN adds the three stat counters.
module rmt_ingress_filter
  import rmt_pkt_pkg::*;
#(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_axis_tuser,
  output logic                              c_axis_tvalid,
  output logic                              c_axis_tlast,
  input  logic                              c_axis_tready,
  input  logic                              ctrl_en,
  output logic [1:0]                        dbg_state
`ifdef RMT_FILTER_STATS_EN
  ,
  output logic [31:0]                       stat_data_pkts,
  output logic [31:0]                       stat_ctrl_pkts,
  output logic [31:0]                       stat_drop_pkts
`endif
);

  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

  filt_state_t state_q, state_d;
  filt_state_t cls, dest;
  logic [15:0] eth_type, dport;
  logic [7:0]  proto;
  logic        is_ctrl, accept;
  logic        m_in_valid, m_in_ready, c_in_valid, c_in_ready;

  // Header fields are big-endian across consecutive wire bytes.
  assign eth_type = {s_axis_tdata[8*ETH_TYPE_OFF +: 8], s_axis_tdata[8*(ETH_TYPE_OFF+1) +: 8]};
  assign proto    = s_axis_tdata[8*IP_PROTO_OFF +: 8];
  assign dport    = {s_axis_tdata[8*UDP_DPORT_OFF +: 8], s_axis_tdata[8*(UDP_DPORT_OFF+1) +: 8]};

  always_comb begin
    is_ctrl = (eth_type == ETHERTYPE_IPV4) && (proto == IPPROTO_UDP) && (dport == CTRL_UDP_PORT);
    if (is_ctrl) cls = ctrl_en ? FWD_CTRL : DROP;
    else         cls = FWD_DATA;
    // In IDLE the presented beat is beat 0, so its own classification decides
    // where it goes; afterwards the latched destination is used.
    dest = (state_q == IDLE) ? cls : state_q;
    case (dest)
      FWD_DATA: s_axis_tready = m_in_ready & ~areset;
      FWD_CTRL: s_axis_tready = c_in_ready & ~areset;
      default:  s_axis_tready = ~areset;
    endcase
    accept     = s_axis_tvalid & s_axis_tready;
    m_in_valid = s_axis_tvalid & ~areset & (dest == FWD_DATA);
    c_in_valid = s_axis_tvalid & ~areset & (dest == FWD_CTRL);
    state_d    = state_q;
    if (accept) state_d = s_axis_tlast ? IDLE : dest;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign dbg_state = state_q;

  axis_reg_slice #(.DW(C_S_AXIS_DATA_WIDTH), .KW(KW), .UW(C_S_AXIS_TUSER_WIDTH)) u_data_slice (
    .clk       (clk),
    .rst       (areset),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .in_data   (s_axis_tdata),
    .in_keep   (s_axis_tkeep),
    .in_user   (s_axis_tuser),
    .in_last   (s_axis_tlast),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .out_keep  (m_axis_tkeep),
    .out_user  (m_axis_tuser),
    .out_last  (m_axis_tlast)
  );

  axis_reg_slice #(.DW(C_S_AXIS_DATA_WIDTH), .KW(KW), .UW(C_S_AXIS_TUSER_WIDTH)) u_ctrl_slice (
    .clk       (clk),
    .rst       (areset),
    .in_valid  (c_in_valid),
    .in_ready  (c_in_ready),
    .in_data   (s_axis_tdata),
    .in_keep   (s_axis_tkeep),
    .in_user   (s_axis_tuser),
    .in_last   (s_axis_tlast),
    .out_valid (c_axis_tvalid),
    .out_ready (c_axis_tready),
    .out_data  (c_axis_tdata),
    .out_keep  (c_axis_tkeep),
    .out_user  (c_axis_tuser),
    .out_last  (c_axis_tlast)
  );

`ifdef RMT_FILTER_STATS_EN
  logic [31:0] data_cnt_q, data_cnt_d;
  logic [31:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        pkt_end;

  always_comb begin
    pkt_end    = accept & s_axis_tlast;
    data_cnt_d = data_cnt_q;
    ctrl_cnt_d = ctrl_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pkt_end && dest == FWD_DATA && data_cnt_q != 32'hFFFF_FFFF) data_cnt_d = data_cnt_q + 32'd1;
    if (pkt_end && dest == FWD_CTRL && ctrl_cnt_q != 32'hFFFF_FFFF) ctrl_cnt_d = ctrl_cnt_q + 32'd1;
    if (pkt_end && dest == DROP     && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      data_cnt_q <= '0;
      ctrl_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      data_cnt_q <= data_cnt_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_data_pkts = data_cnt_q;
  assign stat_ctrl_pkts = ctrl_cnt_q;
  assign stat_drop_pkts = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rmt_ingress_filter.sv
`timescale 1ns/1ps
module tb_rmt_ingress_filter;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 128;
  localparam int BW = DW + KW + UW + 1;
  localparam int CLS_DATA = 0;
  localparam int CLS_CTRL = 1;
  localparam int CLS_DROP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic [DW-1:0] s_axis_tdata, m_axis_tdata, c_axis_tdata;
  logic [KW-1:0] s_axis_tkeep, m_axis_tkeep, c_axis_tkeep;
  logic [UW-1:0] s_axis_tuser, m_axis_tuser, c_axis_tuser;
  logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic c_axis_tvalid, c_axis_tlast, c_axis_tready;
  logic ctrl_en;
  logic [1:0] dbg_state;
`ifdef RMT_FILTER_STATS_EN
  logic [31:0] stat_data_pkts, stat_ctrl_pkts, stat_drop_pkts;
`endif

  rmt_ingress_filter dut (
    .clk           (clk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .c_axis_tdata  (c_axis_tdata),
    .c_axis_tkeep  (c_axis_tkeep),
    .c_axis_tuser  (c_axis_tuser),
    .c_axis_tvalid (c_axis_tvalid),
    .c_axis_tlast  (c_axis_tlast),
    .c_axis_tready (c_axis_tready),
    .ctrl_en       (ctrl_en),
    .dbg_state     (dbg_state)
`ifdef RMT_FILTER_STATS_EN
    ,
    .stat_data_pkts (stat_data_pkts),
    .stat_ctrl_pkts (stat_ctrl_pkts),
    .stat_drop_pkts (stat_drop_pkts)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] m_exp_q[$];
  logic [BW-1:0] c_exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_data_pkts = 0, exp_ctrl_pkts = 0, exp_drop_pkts = 0;
  bit rand_ready = 1'b0;
  bit m_force = 1'b1, c_force = 1'b1;

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Output ready drivers change just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      c_axis_tready = ($urandom_range(0, 3) != 0);
    end else begin
      m_axis_tready = m_force;
      c_axis_tready = c_force;
    end
  end

  // Monitor: a beat is transferred at the next rising edge when valid&ready
  // is seen at the falling edge.
  always @(negedge clk) begin
    if (!areset) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (m_exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL m_unexpected got=%h", m_axis_tdata);
        end else begin
          check("m_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, m_exp_q.pop_front());
        end
      end
      if (c_axis_tvalid && c_axis_tready) begin
        if (c_exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL c_unexpected got=%h", c_axis_tdata);
        end else begin
          check("c_beat", {c_axis_tdata, c_axis_tkeep, c_axis_tuser, c_axis_tlast}, c_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int classify(input logic [7:0] b[64], input bit en);
    int etype, proto, port;
    etype = int'(b[12]) * 256 + int'(b[13]);
    proto = int'(b[23]);
    port  = int'(b[36]) * 256 + int'(b[37]);
    if (etype == 'h0800 && proto == 'h11 && port == 'hF1F2) return en ? CLS_CTRL : CLS_DROP;
    return CLS_DATA;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- driver ----------------
  // Entered and left at a falling edge; consecutive calls stream back-to-back.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [UW-1:0] u, input bit l, input bit en, input int cls);
    bit hs;
    bit first = 1'b1;
    int cycles = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    ctrl_en       = en;
    forever begin
      #4;
      hs = s_axis_tready;
      if (first && cls == CLS_DROP) check("drop_tready", {{(BW-1){1'b0}}, hs}, {{(BW-1){1'b0}}, 1'b1});
      first = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (hs) break;
      cycles++;
      if (cycles > 500) begin
        n_cmp++; n_err++;
        $display("FAIL s_handshake_timeout got=0 exp=1");
        return;
      end
    end
    // One cycle after acceptance the beat sits in its output register.
    if (cls == CLS_DATA) begin
      check("m_latency", {m_axis_tvalid, m_axis_tdata}, {1'b1, d});
    end else if (cls == CLS_CTRL) begin
      check("c_latency", {c_axis_tvalid, c_axis_tdata}, {1'b1, d});
    end
  endtask

  // kind: 0 control header, 1 IPv4/UDP other port, 2 non-IPv4 with ctrl port,
  // 3 IPv4 non-UDP with ctrl port
  task automatic send_pkt(input int kind, input int nbeats, input bit en, input logic [KW-1:0] last_keep);
    logic [7:0] b[64];
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    int cls, port;
    bit l, e;
    for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
    port = (kind == 1) ? 16'h1000 + $urandom_range(0, 16'h8000) : 16'hF1F2;
    b[12] = 8'h08; b[13] = 8'h00; b[23] = 8'h11;
    if (kind == 2) b[13] = 8'h06;
    if (kind == 3) b[23] = 8'h06;
    b[36] = 8'(port >> 8); b[37] = 8'(port);
    cls = classify(b, en);
    if (cls == CLS_DATA) exp_data_pkts++;
    else if (cls == CLS_CTRL) exp_ctrl_pkts++;
    else exp_drop_pkts++;
    for (int j = 0; j < nbeats; j++) begin
      if (j == 0) for (int i = 0; i < 64; i++) d[8*i +: 8] = b[i];
      else d = rand_data();
      l = (j == nbeats - 1);
      k = '1;
      if (l) k = (last_keep != '0) ? last_keep : {$urandom, $urandom | 32'h1};
      u = {$urandom, $urandom, $urandom, $urandom};
      if (cls == CLS_DATA) m_exp_q.push_back({d, k, u, l});
      if (cls == CLS_CTRL) c_exp_q.push_back({d, k, u, l});
      // ctrl_en toggles freely after beat 0; it must not matter.
      e = (j == 0) ? en : 1'($urandom);
      send_beat(d, k, u, l, e, cls);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int cycles = 0;
    s_axis_tvalid = 1'b0;
    while ((m_exp_q.size() != 0 || c_exp_q.size() != 0) && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    check("drain_m_left", BW'(m_exp_q.size()), '0);
    check("drain_c_left", BW'(c_exp_q.size()), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [BW-1:0] held;
    logic [DW-1:0] d0, d1;
    areset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    m_axis_tready = 1'b1; c_axis_tready = 1'b1; ctrl_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valids", {m_axis_tvalid, c_axis_tvalid, s_axis_tready}, '0);
    check("rst_m_out", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, '0);
    check("rst_c_out", {c_axis_tdata, c_axis_tkeep, c_axis_tuser, c_axis_tlast}, '0);
    check("rst_state", BW'(dbg_state), '0);
    areset = 1'b0;
    @(negedge clk);

    // Control forwarding with partial tkeep on the last beat
    send_pkt(0, 2, 1'b1, 64'h00000000000fffff);
    check("ctrl_no_m_valid", BW'(m_axis_tvalid), '0);
    drain();

    // Single-beat data packet
    send_pkt(1, 1, 1'b1, '0);
    check("data_state_idle", BW'(dbg_state), '0);
    check("data_c_idle", BW'(c_axis_tvalid), '0);
    drain();

    // Dropped control packet immediately followed by a data packet
    send_pkt(0, 3, 1'b0, '0);
    send_pkt(1, 2, 1'b1, '0);
    drain();

    // Back-pressure isolation: control beat held, data packet still passes
    c_force = 1'b0;
    @(negedge clk);
    send_pkt(0, 1, 1'b1, '0);
    held = c_exp_q[0];
    send_pkt(3, 2, 1'b1, '0);
    idle(4);
    check("bp_m_done", BW'(m_exp_q.size()), '0);
    check("bp_c_held", {c_axis_tvalid, c_axis_tdata, c_axis_tkeep, c_axis_tuser, c_axis_tlast}, {1'b1, held});
    c_force = 1'b1;
    drain();

    // Reset during beat 2 of a 3-beat data packet: beat 0 leaves, beat 1 is flushed
    d0 = rand_data();
    d1 = rand_data();
    d0[8*12 +: 8] = 8'h86;
    m_exp_q.push_back({d0, {KW{1'b1}}, {UW{1'b0}}, 1'b0});
    s_axis_tvalid = 1'b1; s_axis_tdata = d0; s_axis_tkeep = '1; s_axis_tuser = '0; s_axis_tlast = 1'b0;
    @(negedge clk);
    s_axis_tdata = d1;
    @(posedge clk);
    #2 areset = 1'b1;
    #1;
    check("midrst_valids", {m_axis_tvalid, c_axis_tvalid, s_axis_tready}, '0);
    check("midrst_m_out", {m_axis_tdata, m_axis_tlast}, '0);
    check("midrst_state", BW'(dbg_state), '0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    exp_data_pkts = 0; exp_ctrl_pkts = 0; exp_drop_pkts = 0;
    @(negedge clk);
    check("midrst_m_left", BW'(m_exp_q.size()), '0);
    send_pkt(1, 3, 1'b1, '0);
    drain();

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      send_pkt($urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom), '0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    drain();

`ifdef RMT_FILTER_STATS_EN
    @(negedge clk);
    check("stat_data", BW'(stat_data_pkts), BW'(exp_data_pkts));
    check("stat_ctrl", BW'(stat_ctrl_pkts), BW'(exp_ctrl_pkts));
    check("stat_drop", BW'(stat_drop_pkts), BW'(exp_drop_pkts));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
